// File: rtl/bus_arbiter_sp_if.sv
// Bus-side signal bundle for the split-capable serial bus arbiter.
// master: arbiter view (drives grant/select/status); slave: agent/testbench view.
interface bus_arbiter_sp_if #(
   parameter int NUM_M = 2,
   parameter int NUM_S = 3
);
   logic [NUM_M-1:0] M_REQ;
   logic [NUM_M-1:0] M_GRANT;
   logic             B_BUS_OUT;
   logic [NUM_S-1:0] S_SBSY;
   logic [NUM_S-1:0] AD_SEL;
   logic             B_SPLIT;
   logic             DEC_ERR;
   logic             TO_ERR;
   logic             BUS_BUSY;

   modport master (
      input  M_REQ, B_BUS_OUT, S_SBSY,
      output M_GRANT, AD_SEL, B_SPLIT, DEC_ERR, TO_ERR, BUS_BUSY
   );

   modport slave (
      output M_REQ, B_BUS_OUT, S_SBSY,
      input  M_GRANT, AD_SEL, B_SPLIT, DEC_ERR, TO_ERR, BUS_BUSY
   );
endinterface

// File: rtl/bus_arbiter_sp.sv
// Round-robin bus arbiter with serial slave-select decode and one split slot.
// Optional connection watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | bus free; resume a parked split or arbitrate new requests
// DECODE  | owner granted; shifting in the serial slave-select prefix
// CONNECT | owner connected to the selected slave
// SPLIT   | one cycle after parking the owner; B_SPLIT high, bus released
module bus_arbiter_sp #(
   parameter int NUM_M    = 2,
   parameter int NUM_S    = 3,
   parameter int SEL_BITS = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic             CLK,
   input  logic             RSTN,
   bus_arbiter_sp_if.master bus
);
   localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int BW = (SEL_BITS > 1) ? $clog2(SEL_BITS) : 1;

   typedef enum logic [1:0] {IDLE, DECODE, CONNECT, SPLIT} state_t;
   state_t state_q, state_n;

   logic [MW-1:0]       rr_q, rr_n, owner_q, owner_n, split_m_q, split_m_n;
   logic [SEL_BITS-1:0] sel_q, sel_n, split_s_q, split_s_n, sel_full;
   logic [BW-1:0]       bit_cnt_q, bit_cnt_n;
   logic                split_valid_q, split_valid_n;
   logic [NUM_M-1:0]    grant_q, grant_n;
   logic [NUM_S-1:0]    ad_sel_q, ad_sel_n;
   logic                b_split_q, b_split_n, dec_err_q, dec_err_n, busy_q;

   logic [NUM_S-1:0]    sel_oh, split_oh, sel_full_oh;
   logic [NUM_M-1:0]    owner_oh, park_oh, eligible;
   logic [MW-1:0]       winner, owner_inc;
   logic                req_own, sbsy_sel, resume, win_found, last_bit, bad_sel;
   logic                timeout_hit;

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q, to_cnt_n;
   logic          to_err_q, to_err_n;
   // counter freezes while the connected slave reports busy
   assign timeout_hit  = (to_cnt_q == TW'(TIMEOUT - 1)) && !sbsy_sel;
   assign bus.TO_ERR   = to_err_q;
`else
   assign timeout_hit  = 1'b0;
   assign bus.TO_ERR   = 1'b0;
`endif

   always_comb begin
      sel_full = SEL_BITS'({sel_q, bus.B_BUS_OUT});
      sel_oh      = '0;
      split_oh    = '0;
      sel_full_oh = '0;
      for (int i = 0; i < NUM_S; i++) begin
         sel_oh[i]      = (int'(sel_q) == i);
         split_oh[i]    = (int'(split_s_q) == i);
         sel_full_oh[i] = (int'(sel_full) == i);
      end
      owner_oh           = '0;
      owner_oh[owner_q]  = 1'b1;
      park_oh            = '0;
      park_oh[split_m_q] = split_valid_q;
      eligible  = bus.M_REQ & ~park_oh;
      owner_inc = MW'((int'(owner_q) + 1) % NUM_M);
      req_own   = |(bus.M_REQ & owner_oh);
      sbsy_sel  = |(bus.S_SBSY & sel_oh);
      resume    = split_valid_q && !(|(bus.S_SBSY & split_oh));
      last_bit  = (bit_cnt_q == BW'(SEL_BITS - 1));
      bad_sel   = (int'(sel_full) >= NUM_S) || (split_valid_q && (sel_full == split_s_q));
      // descending scan so the lowest offset from rr_q wins
      winner    = rr_q;
      win_found = 1'b0;
      for (int k = NUM_M - 1; k >= 0; k--) begin
         if (|(eligible & (NUM_M'(1) << ((int'(rr_q) + k) % NUM_M)))) begin
            winner    = MW'((int'(rr_q) + k) % NUM_M);
            win_found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q       <= IDLE;
         rr_q          <= '0;
         owner_q       <= '0;
         sel_q         <= '0;
         bit_cnt_q     <= '0;
         split_valid_q <= 1'b0;
         split_m_q     <= '0;
         split_s_q     <= '0;
         grant_q       <= '0;
         ad_sel_q      <= '0;
         b_split_q     <= 1'b0;
         dec_err_q     <= 1'b0;
         busy_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q      <= '0;
         to_err_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_n;
         rr_q          <= rr_n;
         owner_q       <= owner_n;
         sel_q         <= sel_n;
         bit_cnt_q     <= bit_cnt_n;
         split_valid_q <= split_valid_n;
         split_m_q     <= split_m_n;
         split_s_q     <= split_s_n;
         grant_q       <= grant_n;
         ad_sel_q      <= ad_sel_n;
         b_split_q     <= b_split_n;
         dec_err_q     <= dec_err_n;
         busy_q        <= (state_n != IDLE);
`ifdef ARB_TIMEOUT_EN
         to_cnt_q      <= to_cnt_n;
         to_err_q      <= to_err_n;
`endif
      end
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE: begin
            if (resume)         state_n = CONNECT;
            else if (win_found) state_n = DECODE;
         end
         DECODE: begin
            if (!req_own)      state_n = IDLE;
            else if (last_bit) state_n = bad_sel ? IDLE : CONNECT;
         end
         CONNECT: begin
            if (!req_own)                         state_n = IDLE;
            else if (sbsy_sel && !split_valid_q)  state_n = SPLIT;
            else if (timeout_hit)                 state_n = IDLE;
         end
         SPLIT:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rr_n          = rr_q;
      owner_n       = owner_q;
      sel_n         = sel_q;
      bit_cnt_n     = bit_cnt_q;
      split_valid_n = split_valid_q;
      split_m_n     = split_m_q;
      split_s_n     = split_s_q;
      grant_n       = grant_q;
      ad_sel_n      = ad_sel_q;
      b_split_n     = 1'b0;
      dec_err_n     = 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_n      = to_cnt_q;
      to_err_n      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (resume) begin
               owner_n       = split_m_q;
               sel_n         = split_s_q;
               grant_n       = park_oh;
               ad_sel_n      = split_oh;
               b_split_n     = 1'b1;
               split_valid_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
               to_cnt_n      = '0;
`endif
            end else if (win_found) begin
               owner_n          = winner;
               grant_n          = '0;
               grant_n[winner]  = 1'b1;
               sel_n            = '0;
               bit_cnt_n        = '0;
            end
         end
         DECODE: begin
            if (!req_own) begin
               grant_n = '0;
               rr_n    = owner_inc;
            end else begin
               sel_n     = sel_full;
               bit_cnt_n = bit_cnt_q + BW'(1);
               if (last_bit) begin
                  if (bad_sel) begin
                     dec_err_n = 1'b1;
                     grant_n   = '0;
                     rr_n      = owner_inc;
                  end else begin
                     ad_sel_n = sel_full_oh;
`ifdef ARB_TIMEOUT_EN
                     to_cnt_n = '0;
`endif
                  end
               end
            end
         end
         CONNECT: begin
            if (!req_own) begin
               grant_n  = '0;
               ad_sel_n = '0;
               rr_n     = owner_inc;
            end else if (sbsy_sel && !split_valid_q) begin
               // park the owner; the bus is dropped while SPLIT shows B_SPLIT
               b_split_n     = 1'b1;
               split_valid_n = 1'b1;
               split_m_n     = owner_q;
               split_s_n     = sel_q;
               grant_n       = '0;
               ad_sel_n      = '0;
               rr_n          = owner_inc;
            end else if (timeout_hit) begin
               grant_n  = '0;
               ad_sel_n = '0;
               rr_n     = owner_inc;
`ifdef ARB_TIMEOUT_EN
               to_err_n = 1'b1;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               if (!sbsy_sel) to_cnt_n = to_cnt_q + TW'(1);
`endif
            end
         end
         default: ;
      endcase
   end

   assign bus.M_GRANT  = grant_q;
   assign bus.AD_SEL   = ad_sel_q;
   assign bus.B_SPLIT  = b_split_q;
   assign bus.DEC_ERR  = dec_err_q;
   assign bus.BUS_BUSY = busy_q;
endmodule

// File: tb/tb_bus_arbiter_sp.sv
// Directed self-checking bench for bus_arbiter_sp (NUM_M=2, NUM_S=3, SEL_BITS=2).
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog (TIMEOUT=8).
module tb_bus_arbiter_sp;
   localparam int NUM_M    = 2;
   localparam int NUM_S    = 3;
   localparam int SEL_BITS = 2;
`ifdef ARB_TIMEOUT_EN
   localparam int TIMEOUT  = 8;
`else
   localparam int TIMEOUT  = 64;
`endif

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bus_arbiter_sp_if #(.NUM_M(NUM_M), .NUM_S(NUM_S)) bus ();

   bus_arbiter_sp #(
      .NUM_M(NUM_M), .NUM_S(NUM_S), .SEL_BITS(SEL_BITS), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK (CLK),
      .RSTN(RSTN),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk_g(input string tag, input logic [NUM_M-1:0] exp);
      checks++;
      assert (bus.M_GRANT === exp) else begin
         errors++;
         $error("FAIL %s M_GRANT observed=%b expected=%b", tag, bus.M_GRANT, exp);
      end
   endtask

   task automatic chk_s(input string tag, input logic [NUM_S-1:0] exp);
      checks++;
      assert (bus.AD_SEL === exp) else begin
         errors++;
         $error("FAIL %s AD_SEL observed=%b expected=%b", tag, bus.AD_SEL, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk_g({tag, "_grant"}, '0);
      chk_s({tag, "_adsel"}, '0);
      chk_b({tag, "_bsplit"}, bus.B_SPLIT, 1'b0);
      chk_b({tag, "_decerr"}, bus.DEC_ERR, 1'b0);
      chk_b({tag, "_toerr"}, bus.TO_ERR, 1'b0);
      chk_b({tag, "_busy"}, bus.BUS_BUSY, 1'b0);
   endtask

   // called on the first cycle a grant is visible; returns on the decode-result cycle
   task automatic do_decode(input string tag, input logic [1:0] bits,
                            input logic [NUM_M-1:0] exp_g);
      chk_g({tag, "_grant"}, exp_g);
      bus.B_BUS_OUT = bits[1];
      cyc(1);
      chk_g({tag, "_grant_hold"}, exp_g);
      bus.B_BUS_OUT = bits[0];
      cyc(1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.M_REQ     = '0;
      bus.B_BUS_OUT = 1'b0;
      bus.S_SBSY    = '0;
      #1;
      chk_quiet("rst");
      cyc(2);
      RSTN = 1'b1;
      cyc(1);
      chk_quiet("post_rst");

      // M0 connects to slave 1 and releases, leaving rr at 1
      bus.M_REQ = 2'b01;
      cyc(1);
      do_decode("a", 2'b01, 2'b01);
      chk_s("a_adsel", 3'b010);
      chk_b("a_busy", bus.BUS_BUSY, 1'b1);
      cyc(3);
      bus.M_REQ = 2'b00;
      cyc(1);
      chk_g("a_rel_grant", 2'b00);
      chk_s("a_rel_adsel", 3'b000);

      // both request; rr=1 so M1 wins, then reset mid-CONNECT
      bus.M_REQ = 2'b11;
      cyc(1);
      do_decode("b", 2'b01, 2'b10);
      chk_s("b_adsel", 3'b010);
      cyc(2);
      RSTN = 1'b0;
      #1;
      chk_quiet("mid_rst");
      cyc(3);
      RSTN = 1'b1;
      cyc(1);
      // rr back to 0: M0 first; then alternate M1, M0 under constant demand
      do_decode("rr0", 2'b01, 2'b01);
      chk_s("rr0_adsel", 3'b010);
      cyc(8);
      bus.M_REQ = 2'b10;
      cyc(1);
      chk_g("rr0_idle", 2'b00);
      bus.M_REQ = 2'b11;
      cyc(1);
      do_decode("rr1", 2'b01, 2'b10);
      chk_s("rr1_adsel", 3'b010);
      cyc(8);
      bus.M_REQ = 2'b01;
      cyc(1);
      chk_g("rr1_idle", 2'b00);
      bus.M_REQ = 2'b11;
      cyc(1);
      do_decode("rr2", 2'b01, 2'b01);
      chk_s("rr2_adsel", 3'b010);
      cyc(4);
      bus.M_REQ = 2'b00;
      cyc(2);

      // bad select "11" with NUM_S=3
      bus.M_REQ = 2'b01;
      cyc(1);
      do_decode("bad", 2'b11, 2'b01);
      chk_b("bad_decerr", bus.DEC_ERR, 1'b1);
      chk_g("bad_grant", 2'b00);
      chk_s("bad_adsel", 3'b000);
      chk_b("bad_busy", bus.BUS_BUSY, 1'b0);
      bus.M_REQ = 2'b00;
      cyc(1);
      chk_b("bad_decerr_pulse", bus.DEC_ERR, 1'b0);
      chk_g("bad_grant_after", 2'b00);
      cyc(1);

      // split: M0 to slave 2, slave goes busy, M0 parked
      bus.M_REQ = 2'b01;
      cyc(1);
      do_decode("sp0", 2'b10, 2'b01);
      chk_s("sp0_adsel", 3'b100);
      cyc(2);
      bus.S_SBSY = 3'b100;
      bus.M_REQ  = 2'b11;
      cyc(1);
      chk_b("sp_bsplit", bus.B_SPLIT, 1'b1);
      chk_g("sp_grant", 2'b00);
      chk_s("sp_adsel", 3'b000);
      chk_b("sp_busy", bus.BUS_BUSY, 1'b1);
      cyc(1);
      chk_b("sp_bsplit_pulse", bus.B_SPLIT, 1'b0);
      chk_g("sp_idle_grant", 2'b00);
      cyc(1);
      // M1 selects the split-busy slave 2 -> DEC_ERR
      do_decode("m1a", 2'b10, 2'b10);
      chk_b("m1a_decerr", bus.DEC_ERR, 1'b1);
      chk_g("m1a_grant", 2'b00);
      chk_s("m1a_adsel", 3'b000);
      cyc(1);
      // rr=0 now but M0 is parked, so M1 is granted again
      do_decode("m1b", 2'b00, 2'b10);
      chk_s("m1b_adsel", 3'b001);
      // slot full: slave 0 busy holds the connection
      bus.S_SBSY = 3'b101;
      cyc(3);
      chk_g("full_grant", 2'b10);
      chk_s("full_adsel", 3'b001);
      chk_b("full_bsplit", bus.B_SPLIT, 1'b0);
      bus.S_SBSY = 3'b000;
      cyc(2);
      chk_g("noresume_conn", 2'b10);
      bus.M_REQ = 2'b01;
      cyc(1);
      chk_g("m1_rel_grant", 2'b00);
      chk_s("m1_rel_adsel", 3'b000);
      chk_b("m1_rel_bsplit", bus.B_SPLIT, 1'b0);
      cyc(1);
      chk_g("resume_grant", 2'b01);
      chk_s("resume_adsel", 3'b100);
      chk_b("resume_bsplit", bus.B_SPLIT, 1'b1);
      chk_b("resume_busy", bus.BUS_BUSY, 1'b1);
      cyc(1);
      chk_b("resume_bsplit_pulse", bus.B_SPLIT, 1'b0);
      chk_g("resume_hold", 2'b01);
      bus.M_REQ = 2'b00;
      cyc(1);
      chk_g("resume_rel", 2'b00);
      cyc(1);

      // request drop coincides with SBSY rise: clean release, no split recorded
      bus.M_REQ = 2'b01;
      cyc(1);
      do_decode("sim", 2'b01, 2'b01);
      chk_s("sim_adsel", 3'b010);
      cyc(2);
      bus.M_REQ  = 2'b00;
      bus.S_SBSY = 3'b010;
      cyc(1);
      chk_g("sim_grant", 2'b00);
      chk_s("sim_adsel_rel", 3'b000);
      chk_b("sim_bsplit", bus.B_SPLIT, 1'b0);
      cyc(1);
      chk_b("sim_bsplit2", bus.B_SPLIT, 1'b0);
      chk_b("sim_busy", bus.BUS_BUSY, 1'b0);
      bus.S_SBSY = 3'b000;
      cyc(2);
      chk_g("sim_noresume_grant", 2'b00);
      chk_b("sim_noresume_bsplit", bus.B_SPLIT, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // watchdog: release after TIMEOUT CONNECT cycles, then M1 gets the bus
      bus.M_REQ = 2'b01;
      cyc(1);
      do_decode("to", 2'b01, 2'b01);
      chk_s("to_adsel", 3'b010);
      bus.M_REQ = 2'b11;
      cyc(TIMEOUT - 1);
      chk_b("to_early", bus.TO_ERR, 1'b0);
      chk_g("to_early_grant", 2'b01);
      cyc(1);
      chk_b("to_err", bus.TO_ERR, 1'b1);
      chk_g("to_grant", 2'b00);
      chk_s("to_adsel_rel", 3'b000);
      cyc(1);
      chk_b("to_err_pulse", bus.TO_ERR, 1'b0);
      chk_g("to_next_grant", 2'b10);
      bus.M_REQ = 2'b00;
      cyc(3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bus_arbiter_sp.md
Name: bus_arbiter_sp

Overview:
Central arbiter and slave-select decoder for the serial split-capable bus. Grants the single shared bus to one of NUM_M masters using round-robin priority. Decodes a serial slave-select prefix into a one-hot AD_SEL. Manages one outstanding split transaction: it parks the master whose slave raises SBSY, then resumes that master when the slave is ready.

Parameters:
NUM_M, 2, number of masters (2..4)
NUM_S, 3, number of slaves
SEL_BITS, 2, width of the serial slave-select prefix
TIMEOUT, 64, connection watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
CLK  input  1  bus clock
RSTN  input  1  asynchronous active-low reset
M_REQ  input  NUM_M  per-master request; held high for the whole transaction
M_GRANT  output  NUM_M  one-hot grant, registered
B_BUS_OUT  input  1  serial master-to-bus data, already muxed by grant
S_SBSY  input  NUM_S  per-slave split-busy
AD_SEL  output  NUM_S  one-hot slave select, registered
B_SPLIT  output  1  one-cycle pulse at split entry and at split resume
DEC_ERR  output  1  one-cycle pulse: invalid or split-busy slave select
TO_ERR  output  1  one-cycle pulse: watchdog release
BUS_BUSY  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, RSTN=0): every output is 0; state=IDLE; rr pointer=0; split_valid=0; counters=0. Reset mid-transaction drops grant and select immediately, and any pending split is lost.
- All outputs are registered. Pulses last exactly one cycle.
- States: IDLE, DECODE, CONNECT, SPLIT.
- IDLE, resume path:
  - Condition: split_valid and S_SBSY[split_s]==0.
  - Next cycle: M_GRANT[split_m]=1, AD_SEL[split_s]=1, B_SPLIT=1, split_valid cleared, state -> CONNECT.
  - Resume has priority over new requests.
- IDLE, new request path:
  - Eligible requests are M_REQ masked by the parked master while split_valid.
  - Winner is the first eligible index at or above rr pointer, wrapping.
  - Next cycle: M_GRANT=one-hot winner, bit counter=0, state -> DECODE.
  - With no eligible request, stay in IDLE.
- DECODE:
  - Shift B_BUS_OUT into sel, MSB first, one bit per cycle for SEL_BITS cycles (the first bit is sampled the cycle M_GRANT is high).
  - After the last bit, if sel>=NUM_S, or split_valid with sel==split_s: DEC_ERR=1, M_GRANT=0, state -> IDLE, rr pointer = owner+1.
  - Otherwise: AD_SEL[sel]=1, state -> CONNECT.
  - If M_REQ[owner] drops during DECODE: abort to IDLE, no AD_SEL, no DEC_ERR.
- CONNECT:
  - If M_REQ[owner]==0: M_GRANT=0, AD_SEL=0, rr pointer = owner+1, state -> IDLE. Release wins over a simultaneous S_SBSY rise.
  - Else if S_SBSY[sel] rises and split_valid==0: state -> SPLIT.
  - Else if S_SBSY rises and split_valid==1 (slot full): no split is taken; the connection holds and the master waits.
- SPLIT (1 cycle):
  - B_SPLIT=1; record split_m=owner and split_s=sel; split_valid=1.
  - M_GRANT=0, AD_SEL=0, rr pointer = owner+1, state -> IDLE.
  - The parked master keeps M_REQ high and is masked until resume.
- Rules:
  - At most one bit of M_GRANT and one bit of AD_SEL is high at any time.
  - AD_SEL is never high without M_GRANT.
  - There is always at least one idle cycle between consecutive grants.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in CONNECT and clears on entry. When it reaches TIMEOUT with S_SBSY[sel]==0, the arbiter forces release: TO_ERR=1, M_GRANT=0, AD_SEL=0, state -> IDLE, rr pointer advances. The counter is frozen while S_SBSY[sel]==1.
- Undefined: no counter; TO_ERR is tied to 0 and the connection is unbounded.

Test Plan:
- Reset: RSTN low for 3 cycles mid-CONNECT -> all outputs 0 immediately; first grant after release goes to M0 (rr=0).
- Round-robin: M_REQ=2'b11 held, each master holds request for 10 cycles after grant, select bits "01" -> grants alternate M0, M1, M0; AD_SEL=3'b010 in each CONNECT.
- Bad select: M0 sends "11" with NUM_S=3 -> DEC_ERR pulse on the cycle after the second bit; M_GRANT=0; no AD_SEL.
- Split and resume:
  - M0 connects to slave 2; S_SBSY[2] rises -> B_SPLIT pulse, M0 parked.
  - M1 is granted, sends "10" -> DEC_ERR; M1 then sends "00" -> connects to slave 0.
  - M1 releases while S_SBSY[2]=0 -> next cycle M_GRANT=01, AD_SEL=100, B_SPLIT pulse.
- Simultaneous: M_REQ[owner] falls in the same cycle S_SBSY[sel] rises -> clean release, no B_SPLIT, split_valid stays 0.
- ARB_TIMEOUT_EN with TIMEOUT=8: M0 holds request for 20 cycles -> TO_ERR pulse after 8 CONNECT cycles; grant passes to M1 if it is requesting.
